// File: rtl/quiz_round_ctrl.sv
// Round controller for the speed mental-conversion quiz: draws questions from an
// LFSR, times the answer window on slow_clk ticks, checks answers and keeps score.
module quiz_round_ctrl #(
    parameter int         TIME_LIMIT = 10,
    parameter int         NUM_ROUNDS = 5,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       slow_clk,
    input  logic       start,
    input  logic [7:0] answer,
    input  logic       answer_valid,
    output logic [7:0] question,
    output logic       q_valid,
    output logic [3:0] time_left,
    output logic       correct,
    output logic       timeout,
    output logic [3:0] score,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASK,
        S_WAIT,
        S_RESULT,
        S_DONE
    } state_t;

    localparam logic [3:0] TIME_INIT  = 4'(TIME_LIMIT);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] MAX_SCORE  = 4'(NUM_ROUNDS);

    state_t     state;
    state_t     state_next;
    logic       slow_q;
    logic       tick;
    logic       hit;
    logic [7:0] lfsr;
    logic [3:0] round;

    // slow_clk is only sampled as data; its rising edge becomes a one-cycle tick
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            slow_q <= 1'b0;
        end else begin
            slow_q <= slow_clk;
        end
    end

    assign tick = slow_clk & ~slow_q;
    assign hit  = (answer == question);

    // Fibonacci x^8+x^6+x^5+x^4+1, free-running so question timing depends on the player
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        q_valid    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_ASK;
                end
            end
            S_ASK: begin
                busy       = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                busy    = 1'b1;
                q_valid = 1'b1;
                // a submitted answer beats a coincident final tick
                if (answer_valid) begin
                    state_next = S_RESULT;
                end else if (tick && (time_left == 4'd1)) begin
                    state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                busy = 1'b1;
                if (tick) begin
                    state_next = (round == LAST_ROUND) ? S_DONE : S_ASK;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = S_ASK;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            question  <= 8'h00;
            time_left <= 4'd0;
            correct   <= 1'b0;
            timeout   <= 1'b0;
            score     <= 4'd0;
            round     <= 4'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        score <= 4'd0;
                        round <= 4'd0;
                    end
                end
                S_ASK: begin
                    question  <= lfsr;
                    time_left <= TIME_INIT;
                    correct   <= 1'b0;
                    timeout   <= 1'b0;
                end
                S_WAIT: begin
                    if (answer_valid) begin
                        correct <= hit;
                        if (hit && (score != MAX_SCORE)) begin
                            score <= score + 4'd1;
                        end
                    end else if (tick) begin
                        time_left <= time_left - 4'd1;
                        if (time_left == 4'd1) begin
                            timeout <= 1'b1;
                        end
                    end
                end
                S_RESULT: begin
                    if (tick && (round != LAST_ROUND)) begin
                        round <= round + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed bench for quiz_round_ctrl with TIME_LIMIT=3, NUM_ROUNDS=2 and a
// 10-cycle slow_clk square wave driven on the falling edge of clk_in.
module tb_quiz_round_ctrl;

    localparam int         TL   = 3;
    localparam int         NR   = 2;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       slow_clk;
    logic       start;
    logic [7:0] answer;
    logic       answer_valid;
    logic [7:0] question;
    logic       q_valid;
    logic [3:0] time_left;
    logic       correct;
    logic       timeout;
    logic [3:0] score;
    logic       busy;
    logic       done;

    int         checks   = 0;
    int         failures = 0;
    int         slow_cnt = 0;
    bit         slow_en  = 1'b0;
    logic       slow_prev;
    logic [7:0] lfsr_m;
    logic [7:0] q_exp;

    quiz_round_ctrl #(
        .TIME_LIMIT(TL),
        .NUM_ROUNDS(NR),
        .LFSR_SEED (SEED)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .slow_clk    (slow_clk),
        .start       (start),
        .answer      (answer),
        .answer_valid(answer_valid),
        .question    (question),
        .q_valid     (q_valid),
        .time_left   (time_left),
        .correct     (correct),
        .timeout     (timeout),
        .score       (score),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] next_lfsr(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Advance to the next falling edge; track the LFSR model and the slow wave.
    task automatic step();
        @(negedge clk_in);
        lfsr_m    = reset ? SEED : next_lfsr(lfsr_m);
        slow_prev = slow_clk;
        if (slow_en) slow_cnt = (slow_cnt + 1) % 10;
        else         slow_cnt = 0;
        slow_clk = slow_en && (slow_cnt >= 5);
    endtask

    // Step until the coming rising edge carries a tick, then step through it.
    task automatic wait_tick(input string tag);
        int n = 0;
        while (!(slow_clk && !slow_prev) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            checks++; failures++;
            $display("FAIL %s: no slow tick seen within %0d cycles", tag, n);
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; answer = 8'h00; answer_valid = 1'b0;
        slow_en = 1'b0; slow_clk = 1'b0; slow_prev = 1'b0; lfsr_m = SEED;
        repeat (3) step();
        checks++;
        if ({question, q_valid, time_left, correct, timeout, score, busy, done} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs: got q=%h qv=%b tl=%0d c=%b to=%b s=%0d b=%b d=%b want all 0",
                     question, q_valid, time_left, correct, timeout, score, busy, done);
        end
        reset = 1'b0;
    endtask

    task automatic test_start();
        slow_en = 1'b1; slow_cnt = 0;
        start = 1'b1; step(); start = 1'b0;
        q_exp = lfsr_m;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ask_busy: got %b want 1", busy); end
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL ask_qvalid: got %b want 0", q_valid); end
        step();
        checks++; if (q_valid !== 1'b1) begin failures++; $display("FAIL start_qvalid: got %b want 1", q_valid); end
        checks++; if (question !== 8'h4A) begin failures++; $display("FAIL start_question: got %h want 4a", question); end
        checks++; if (time_left !== 4'd3) begin failures++; $display("FAIL start_time_left: got %0d want 3", time_left); end
        checks++; if (score !== 4'd0) begin failures++; $display("FAIL start_score: got %0d want 0", score); end
    endtask

    task automatic test_correct();
        start = 1'b1; step(); start = 1'b0;
        checks++; if (q_valid !== 1'b1 || question !== q_exp) begin
            failures++; $display("FAIL start_in_wait: got qv=%b q=%h want qv=1 q=%h", q_valid, question, q_exp);
        end
        answer = q_exp; answer_valid = 1'b1; step(); answer_valid = 1'b0;
        checks++; if (correct !== 1'b1) begin failures++; $display("FAIL right_correct: got %b want 1", correct); end
        checks++; if (score !== 4'd1) begin failures++; $display("FAIL right_score: got %0d want 1", score); end
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL right_qvalid: got %b want 0", q_valid); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL right_timeout: got %b want 0", timeout); end
        answer_valid = 1'b1; step(); answer_valid = 1'b0;
        checks++; if (score !== 4'd1) begin failures++; $display("FAIL answer_in_result: score got %0d want 1", score); end
        wait_tick("result_to_ask");
        q_exp = lfsr_m;
        step();
        checks++; if (question !== q_exp) begin failures++; $display("FAIL round2_question: got %h want %h", question, q_exp); end
    endtask

    task automatic test_timeout();
        int  ticks = 0;
        int  n = 0;
        bit  mid = 1'b0;
        while (ticks < 3 && n < 100) begin
            if (slow_clk && !slow_prev) ticks++;
            step();
            n++;
            if (ticks == 1 && !mid) begin
                mid = 1'b1;
                checks++; if (time_left !== 4'd2) begin failures++; $display("FAIL tick1_time_left: got %0d want 2", time_left); end
            end
        end
        if (n >= 100) begin checks++; failures++; $display("FAIL timeout_wait: only %0d ticks in %0d cycles", ticks, n); end
        checks++; if (time_left !== 4'd0) begin failures++; $display("FAIL to_time_left: got %0d want 0", time_left); end
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_flag: got %b want 1", timeout); end
        checks++; if (score !== 4'd1) begin failures++; $display("FAIL to_score: got %0d want 1", score); end
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL to_qvalid: got %b want 0", q_valid); end
        wait_tick("final_result");
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL game_done: got done=%b busy=%b want 1 0", done, busy);
        end
        checks++; if (timeout !== 1'b1 || score !== 4'd1) begin
            failures++; $display("FAIL done_hold: got to=%b score=%0d want 1 1", timeout, score);
        end
    endtask

    task automatic test_collision();
        int n = 0;
        start = 1'b1; step(); start = 1'b0;
        q_exp = lfsr_m;
        checks++; if (score !== 4'd0) begin failures++; $display("FAIL restart_score: got %0d want 0", score); end
        step();
        while (!(time_left == 4'd1 && slow_clk && !slow_prev) && q_valid && n < 60) begin
            step();
            n++;
        end
        if (!(time_left == 4'd1 && q_valid)) begin
            checks++; failures++; $display("FAIL collide_sync: got tl=%0d qv=%b want tl=1 qv=1", time_left, q_valid);
        end
        answer = q_exp ^ 8'hFF; answer_valid = 1'b1; step(); answer_valid = 1'b0;
        checks++; if (correct !== 1'b0) begin failures++; $display("FAIL collide_correct: got %b want 0", correct); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL collide_timeout: got %b want 0", timeout); end
        checks++; if (time_left !== 4'd1) begin failures++; $display("FAIL collide_time_left: got %0d want 1", time_left); end
        checks++; if (score !== 4'd0) begin failures++; $display("FAIL collide_score: got %0d want 0", score); end
        wait_tick("collide_result");
        q_exp = lfsr_m;
        step();
        answer = q_exp; answer_valid = 1'b1; step(); answer_valid = 1'b0;
        checks++; if (score !== 4'd1 || correct !== 1'b1) begin
            failures++; $display("FAIL collide_round2: got score=%0d c=%b want 1 1", score, correct);
        end
        wait_tick("collide_final");
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL collide_done: got %b want 1", done); end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            if (r == 0) begin
                start = 1'b1; step(); start = 1'b0;
            end else begin
                wait_tick("b2b_result");
            end
            q_exp = lfsr_m;
            step();
            checks++; if (question !== q_exp || q_valid !== 1'b1) begin
                failures++; $display("FAIL b2b_question_r%0d: got q=%h qv=%b want %h 1", r, question, q_valid, q_exp);
            end
            answer = q_exp; answer_valid = 1'b1; step(); answer_valid = 1'b0;
            checks++; if (score !== 4'(r + 1)) begin
                failures++; $display("FAIL b2b_score_r%0d: got %0d want %0d", r, score, r + 1);
            end
        end
        wait_tick("b2b_final");
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL b2b_done: got done=%b busy=%b want 1 0", done, busy);
        end
        checks++; if (score !== 4'd2 || correct !== 1'b1) begin
            failures++; $display("FAIL b2b_final_score: got score=%0d c=%b want 2 1", score, correct);
        end
        start = 1'b1; step(); start = 1'b0;
        q_exp = lfsr_m;
        checks++; if (score !== 4'd0 || done !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL b2b_restart: got score=%0d done=%b busy=%b want 0 0 1", score, done, busy);
        end
        step();
        checks++; if (question !== q_exp || q_valid !== 1'b1) begin
            failures++; $display("FAIL b2b_new_question: got q=%h qv=%b want %h 1", question, q_valid, q_exp);
        end
    endtask

    task automatic test_reset_mid();
        answer = q_exp; answer_valid = 1'b1; step(); answer_valid = 1'b0;
        wait_tick("pre_reset_result");
        step();
        checks++; if (q_valid !== 1'b1 || score !== 4'd1) begin
            failures++; $display("FAIL pre_reset_state: got qv=%b score=%0d want 1 1", q_valid, score);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({question, q_valid, time_left, correct, timeout, score, busy, done} !== 21'd0) begin
            failures++;
            $display("FAIL async_reset: got q=%h qv=%b tl=%0d c=%b to=%b s=%0d b=%b d=%b want all 0",
                     question, q_valid, time_left, correct, timeout, score, busy, done);
        end
        slow_en = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (254) step();
        start = 1'b1; step(); start = 1'b0;
        step();
        checks++; if (question !== 8'hA5 || q_valid !== 1'b1) begin
            failures++; $display("FAIL lfsr_period: got q=%h qv=%b want a5 1", question, q_valid);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_correct();
        test_timeout();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/quiz_round_ctrl.md
# quiz_round_ctrl

Round controller for the speed mental-conversion quiz. It consumes the divided `slow_clk` produced by the clock divider on the same `clk_in` domain and uses its rising edges as the one-second tick. It draws each question from a free-running 8-bit LFSR, counts down the answer window, checks the player's answer and keeps score over a fixed number of rounds. The player converts the shown value and enters it on switches; the answer is correct when the entered value equals `question`.

## Interface

Parameters:
- `TIME_LIMIT`, 10: answer window in slow ticks; legal range 1..15.
- `NUM_ROUNDS`, 5: rounds per game; legal range 1..15.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `clk_in` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `slow_clk` in 1: divided clock from the divider, registered on `clk_in`; used as data only, never as a clock.
- `start` in 1: start pulse; honoured only in IDLE and DONE.
- `answer` in 8: player answer.
- `answer_valid` in 1: one-cycle submit strobe; honoured only in WAIT.
- `question` out 8: current question value.
- `q_valid` out 1: high while in WAIT.
- `time_left` out 4: remaining ticks.
- `correct` out 1: last answer matched.
- `timeout` out 1: last round expired.
- `score` out 4: correct answers this game.
- `busy` out 1: state is ASK, WAIT or RESULT.
- `done` out 1: game finished.

## Operation

- Tick detect:
  - `slow_q` is `slow_clk` delayed by one register.
  - `tick = slow_clk & ~slow_q`, which gives one `clk_in` cycle per rising edge of `slow_clk`.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Advances every `clk_in` cycle in every state.
  - Period is 255 and it never reaches 0.
- States and transitions:
  - IDLE
    - On `start`: `score`<=0, `round`<=0, go to ASK.
  - ASK (exactly one cycle)
    - `question`<=lfsr, `time_left`<=`TIME_LIMIT`, `correct`<=0, `timeout`<=0.
    - Go to WAIT.
  - WAIT
    - If `answer_valid`: `correct`<=(`answer`==`question`), and `score`+1 if correct. Go to RESULT.
    - Else if `tick` and `time_left`==1: `time_left`<=0, `timeout`<=1. Go to RESULT.
    - Else if `tick`: `time_left`<=`time_left`-1.
  - RESULT
    - Hold `correct`, `timeout` and `question`.
    - On the first `tick` seen in RESULT: if `round`==`NUM_ROUNDS`-1 go to DONE, else `round`+1 and go to ASK.
  - DONE
    - `done`=1; `score` and flags are held.
    - On `start`: clear `score` and `round`, go to ASK.
- Priority:
  - An `answer_valid` and a `tick` in the same WAIT cycle: the answer wins and `time_left` is not decremented.
  - `start` outside IDLE and DONE is ignored.
  - `answer_valid` outside WAIT is ignored.
- Width and saturation:
  - `score` never exceeds `NUM_ROUNDS`, so it never wraps.
  - `round` is 4 bits.

## Timing

- Reset value of all outputs is 0, including `question`. State is IDLE, `slow_q`=0, lfsr=`LFSR_SEED`.
- Reset asserted mid-game returns the block to IDLE immediately and asynchronously.
- Start sequence:
  - `start` sampled high at edge N puts the block in ASK for cycle N+1.
  - At edge N+2, `question` is loaded and `q_valid`=1.
- `question` equals the LFSR value present during the ASK cycle.
- Answer latency: `answer_valid` at edge M makes `correct`/`score` visible after M and drops `q_valid` after M, i.e. 1 cycle.
- Timeout:
  - `timeout` rises after the `TIME_LIMIT`-th tick counted in WAIT.
  - A tick landing in the ASK cycle is not counted.
- Pause between rounds: RESULT lasts until the next tick, which is 1 to one full slow period long.
- `done` rises 1 cycle after the final RESULT tick.
- `busy` and `done` are combinational from state.

## Test plan

Bench parameters: `TIME_LIMIT`=3, `NUM_ROUNDS`=2, `LFSR_SEED`=8'hA5. The bench drives `slow_clk` as a square wave with a period of 10 `clk_in` cycles.

1. Reset, then `start` -> after 2 cycles `q_valid`=1, `question`=expected lfsr value, `time_left`=3. The bench model predicts `question` from the seed and cycle count.
2. In WAIT, `answer`=`question` with `answer_valid` -> next cycle `correct`=1, `score`=1, `q_valid`=0, `timeout`=0.
3. No answer -> after 3 rising edges of `slow_clk`: `time_left`=0, `timeout`=1, `score` unchanged.
4. `answer_valid` with a wrong answer, coincident with the tick at `time_left`=1 -> `correct`=0, `timeout`=0, `time_left` stays 1.
5. Two correct rounds -> `done`=1, `score`=2, `busy`=0. A further `start` -> `score`=0 and a new question is issued.
6. `reset` pulsed during WAIT -> all outputs 0 at once. After 255 cycles of free-run the LFSR returns to 8'hA5 and never shows 0.
